hidden_ram_ctrl: RTL and testbench

- Controller and arbiter for the 32x8 hidden-unit RAM (synchronous write, registered read address).
- Shares the RAM's single address port between two requesters:
  - a host write port, used by the weight/activation loader;
  - a burst-read sequencer, which streams consecutive hidden-unit values to the downstream MAC.
- Sits between the loader/MAC logic and the RAM instance. It drives the RAM address, data and we, and receives q.

---
 rtl/hidden_ram_ctrl_pkg.sv | 27 ++
 rtl/hidden_ram_ctrl_if.sv | 31 +++
 rtl/hidden_ram_rr_arb.sv | 46 ++++
 rtl/hidden_ram_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hidden_ram_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hidden_ram_ctrl_pkg.sv
// hidden_ram_pkg: shared constants and types for the hidden-unit RAM controller.
// Contents:
//   DATA_WIDTH / ADDR_WIDTH / LEN_WIDTH - word, address and burst-length widths
//   RAM_DEPTH                           - number of words in the hidden-unit RAM
//   seq_state_t                         - burst sequencer states
//   addr_inc()                          - address increment that wraps at RAM_DEPTH
package hidden_ram_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // The address is exactly ADDR_WIDTH bits wide, so the natural overflow of
  // the add gives the modulo-RAM_DEPTH wrap (31 -> 0).
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/hidden_ram_ctrl_if.sv
// hidden_ram_ctrl_if: single-port bus between the controller and the
// 32x8 hidden-unit RAM (synchronous write, registered read address).
// Signals:
//   ram_addr - word address (write address, or read address captured by the RAM)
//   ram_data - write data
//   ram_we   - write enable
//   ram_q    - read data, valid the cycle after the address was presented
// Modports: master = controller side, slave = RAM side.
interface hidden_ram_ctrl_if;
  import hidden_ram_pkg::*;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    output ram_addr,
    output ram_data,
    output ram_we,
    input  ram_q
  );

  modport slave (
    input  ram_addr,
    input  ram_data,
    input  ram_we,
    output ram_q
  );

endinterface

// File: rtl/hidden_ram_rr_arb.sv
// hidden_ram_rr_arb: two-requester round-robin arbiter with a one-bit
// priority pointer. Grants are combinational; the pointer only moves when
// both requesters are active, and then it moves to the requester that lost.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (pointer returns to requester 0)
//   req  - request vector, bit 0 = requester 0, bit 1 = requester 1
//   gnt  - one-hot (or zero) grant vector, same bit order as req
module hidden_ram_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0: requester 0 wins the next contended cycle, 1: requester 1 wins it.
  logic ptr_q;
  logic ptr_d;

  // Grant selection and pointer update.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (req == 2'b11) begin
      if (ptr_q == 1'b0) begin
        gnt   = 2'b01;
        ptr_d = 1'b1;
      end else begin
        gnt   = 2'b10;
        ptr_d = 1'b0;
      end
    end else begin
      gnt = req;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hidden_ram_ctrl.sv
// hidden_ram_ctrl: controller/arbiter for the 32x8 hidden-unit RAM.
// Shares the RAM's single address port between a host write port and a
// burst-read sequencer that streams consecutive words to the MAC.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   hw_req/hw_addr/hw_data    - host write request (held until hw_gnt)
//   hw_gnt                    - combinational grant, high when the write hits the RAM
//   seq_start/seq_base/seq_len- burst start, first address, word count (0..32)
//   seq_busy, seq_done        - burst in progress (BURST/DRAIN), one-cycle done pulse
//   rd_data/rd_valid/rd_last  - streamed read words, last-word qualifier
//   stall_cnt                 - cycles the sequencer lost arbitration (optional)
//   ram                       - RAM bus (hidden_ram_ctrl_if.master)
// Build option: define HIDDEN_RAM_CTRL_STALL_CNT_EN to add the stall_cnt port.
module hidden_ram_ctrl
  import hidden_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hw_req,
  input  logic [ADDR_WIDTH-1:0] hw_addr,
  input  logic [DATA_WIDTH-1:0] hw_data,
  output logic                  hw_gnt,
  input  logic                  seq_start,
  input  logic [ADDR_WIDTH-1:0] seq_base,
  input  logic [LEN_WIDTH-1:0]  seq_len,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  hidden_ram_ctrl_if.master     ram
);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  cnt_inc_s;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;

  logic [1:0]            arb_req_s;
  logic [1:0]            arb_gnt_s;
  logic                  host_win_s;
  logic                  seq_win_s;

  // The sequencer only competes for the port while in BURST; the host
  // request is masked during reset so nothing is granted then.
  assign arb_req_s  = {(state_q == BURST), (hw_req & ~rst)};
  assign host_win_s = arb_gnt_s[0];
  assign seq_win_s  = arb_gnt_s[1];
  assign cnt_inc_s  = cnt_q + LEN_WIDTH'(1);

  hidden_ram_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (arb_req_s),
    .gnt (arb_gnt_s)
  );

  // RAM port drive: host write, sequencer read address, or all-zero idle.
  always_comb begin
    ram.ram_addr = '0;
    ram.ram_data = '0;
    ram.ram_we   = 1'b0;
    if (host_win_s) begin
      ram.ram_addr = hw_addr;
      ram.ram_data = hw_data;
      ram.ram_we   = 1'b1;
    end else if (seq_win_s) begin
      ram.ram_addr = addr_q;
    end else begin
      ram.ram_addr = '0;
    end
  end

  // Sequencer next-state and read-issue bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_start) begin
          if (seq_len == {LEN_WIDTH{1'b0}}) begin
            state_d = DONE;
          end else begin
            addr_d  = seq_base;
            len_d   = seq_len;
            cnt_d   = '0;
            state_d = BURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        // A cycle lost to the host issues nothing, so no rd_valid follows.
        if (seq_win_s) begin
          addr_d     = addr_inc(addr_q);
          cnt_d      = cnt_inc_s;
          rd_valid_d = 1'b1;
          if (cnt_inc_s == len_q) begin
            rd_last_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            state_d = BURST;
          end
        end else begin
          state_d = BURST;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer and read-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign hw_gnt   = host_win_s;
  assign seq_busy = (state_q == BURST) || (state_q == DRAIN);
  assign seq_done = (state_q == DONE);
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  // The RAM registers the address, so ram_q already holds the word for the
  // read issued last cycle; force zero when no read word is present.
  assign rd_data  = rd_valid_q ? ram.ram_q : '0;

`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: cleared by an accepted start, saturating count of lost BURST cycles.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && seq_start) begin
      stall_d = 16'h0000;
    end else if ((state_q == BURST) && !seq_win_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_hidden_ram_ctrl.sv
// tb_hidden_ram_ctrl: self-checking bench for hidden_ram_ctrl with a
// behavioural 32x8 RAM and a port-operation-order reference model.
module tb_hidden_ram_ctrl;
  import hidden_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hw_req = 1'b0;
  logic [4:0] hw_addr = 5'd0;
  logic [7:0] hw_data = 8'h00;
  logic       hw_gnt;
  logic       seq_start = 1'b0;
  logic [4:0] seq_base = 5'd0;
  logic [5:0] seq_len = 6'd0;
  logic       seq_busy, seq_done, rd_valid, rd_last;
  logic [7:0] rd_data;
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  hidden_ram_ctrl_if ram_if ();

  hidden_ram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .hw_req    (hw_req),
    .hw_addr   (hw_addr),
    .hw_data   (hw_data),
    .hw_gnt    (hw_gnt),
    .seq_start (seq_start),
    .seq_base  (seq_base),
    .seq_len   (seq_len),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .ram       (ram_if)
  );

  // Behavioural RAM: synchronous write, registered read address.
  logic [7:0] mem [0:RAM_DEPTH-1];
  logic [4:0] raddr_q;
  always @(posedge clk) begin
    if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_data;
    raddr_q <= ram_if.ram_addr;
  end
  assign ram_if.ram_q = mem[raddr_q];

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] ref_mem [0:RAM_DEPTH-1];
  bit         ptr_m = 1'b0;           // 0: host wins next contention
  logic [4:0] wq_a[$];
  logic [7:0] wq_d[$];
  logic [7:0] exp_data[$];
  int         exp_vcyc[$];
  int         exp_gcyc[$];
  int         exp_done, exp_busy_n, exp_stall;

  // Observations.
  logic [7:0] obs_data[$];
  int         obs_vcyc[$];
  int         obs_lcyc[$];
  int         obs_gcyc[$];
  int         obs_done, obs_done_n, obs_busy_n, obs_busy_first, obs_busy_last, obs_bad;
  bit         obs_timeout;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Orders every port operation of a burst (cycle 1 onward) by the
  // arbitration rules and derives expected read data and timing.
  task automatic model_burst(input logic [4:0] base, input int len);
    int issued = 0;
    int cyc = 1;
    int wi = 0;
    int post;
    logic [4:0] a;
    a = base;
    exp_data.delete(); exp_vcyc.delete(); exp_gcyc.delete();
    exp_stall = 0;
    while (issued < len) begin
      if (wi < wq_a.size() && ptr_m == 1'b0) begin
        ref_mem[wq_a[wi]] = wq_d[wi];
        exp_gcyc.push_back(cyc);
        wi++;
        exp_stall++;
        ptr_m = 1'b1;
      end else begin
        if (wi < wq_a.size()) ptr_m = 1'b0;
        exp_data.push_back(ref_mem[a]);
        exp_vcyc.push_back(cyc + 1);
        a = a + 5'd1;
        issued++;
      end
      cyc++;
    end
    if (len == 0) begin
      exp_done = 1; exp_busy_n = 0; post = 1;
    end else begin
      exp_done = cyc + 1; exp_busy_n = cyc; post = cyc;
    end
    while (wi < wq_a.size()) begin
      ref_mem[wq_a[wi]] = wq_d[wi];
      exp_gcyc.push_back(post);
      post++;
      wi++;
    end
  endtask

  // Drives one burst plus queued host writes and records what the DUT does.
  task automatic burst_run(input logic [4:0] base, input logic [5:0] len, input int restart_cyc);
    int wi = 0;
    int cyc;
    bit done_seen = 1'b0;
    obs_data.delete(); obs_vcyc.delete(); obs_lcyc.delete(); obs_gcyc.delete();
    obs_done = -1; obs_done_n = 0; obs_busy_n = 0; obs_busy_first = -1; obs_busy_last = -1;
    obs_bad = 0; obs_timeout = 1'b0;
    seq_start = 1'b1; seq_base = base; seq_len = len; hw_req = 1'b0;
    tick;
    cyc = 1;
    while (!(done_seen && wi >= wq_a.size())) begin
      if (cyc > 300) begin
        obs_timeout = 1'b1;
        break;
      end
      if (cyc == restart_cyc) begin
        seq_start = 1'b1; seq_base = base + 5'd9; seq_len = 6'd3;
      end else begin
        seq_start = 1'b0;
      end
      hw_req = (wi < wq_a.size());
      if (hw_req) begin
        hw_addr = wq_a[wi]; hw_data = wq_d[wi];
      end
      #3;
      if (rd_valid === 1'b1) begin
        obs_data.push_back(rd_data); obs_vcyc.push_back(cyc);
      end else if (rd_data !== 8'h00) begin
        obs_bad++;
      end
      if (rd_last === 1'b1) obs_lcyc.push_back(cyc);
      if (seq_done === 1'b1) begin
        obs_done_n++; obs_done = cyc; done_seen = 1'b1;
      end
      if (seq_busy === 1'b1) begin
        obs_busy_n++;
        if (obs_busy_first < 0) obs_busy_first = cyc;
        obs_busy_last = cyc;
      end
      if (hw_gnt === 1'b1) begin
        obs_gcyc.push_back(cyc);
        if (ram_if.ram_we !== 1'b1 || ram_if.ram_addr !== hw_addr || ram_if.ram_data !== hw_data) obs_bad++;
        wi++;
      end
      tick;
      cyc++;
    end
    seq_start = 1'b0; hw_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; hw_req = 1'b0; seq_start = 1'b0;
    tick;
    hw_req = 1'b1; hw_addr = 5'd3; hw_data = 8'h55;
    #3;
    checks++;
    if (hw_gnt !== 1'b0 || ram_if.ram_we !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: gnt=%b we=%b required 0 0", hw_gnt, ram_if.ram_we);
    end
    hw_req = 1'b0;
    #1;
    checks++;
    if ({seq_busy, seq_done, rd_valid, rd_last, hw_gnt, ram_if.ram_we} !== 6'b0 ||
        rd_data !== 8'h00 || ram_if.ram_addr !== 5'd0 || ram_if.ram_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b v=%b l=%b gnt=%b we=%b data=%h addr=%h wdata=%h required all 0",
               seq_busy, seq_done, rd_valid, rd_last, hw_gnt, ram_if.ram_we, rd_data, ram_if.ram_addr, ram_if.ram_data);
    end
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_stall: got %0d required 0", stall_cnt);
    end
`endif
    tick;
    rst = 1'b0;
    ptr_m = 1'b0;
  endtask

  task automatic test_host_fill;
    for (int i = 0; i < 32; i++) begin
      hw_req = 1'b1; hw_addr = 5'(i); hw_data = 8'hA0 + 8'(i);
      #3;
      checks++;
      if (hw_gnt !== 1'b1 || ram_if.ram_we !== 1'b1 || ram_if.ram_addr !== 5'(i) || ram_if.ram_data !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL fill[%0d]: gnt=%b we=%b addr=%h data=%h required 1 1 %h %h",
                 i, hw_gnt, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_data, 5'(i), 8'hA0 + 8'(i));
      end
      ref_mem[i] = 8'hA0 + 8'(i);
      tick;
    end
    hw_req = 1'b0;
    #3;
    checks++;
    if (ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== 5'd0 || ram_if.ram_data !== 8'h00 || hw_gnt !== 1'b0) begin
      errors++;
      $display("FAIL idle_port: we=%b addr=%h data=%h gnt=%b required 0 0 0 0",
               ram_if.ram_we, ram_if.ram_addr, ram_if.ram_data, hw_gnt);
    end
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++; $display("FAIL fill_stall: got %0d required 0", stall_cnt);
    end
`endif
    tick;
  endtask

  // Generic burst scenario: model, run, compare everything observed.
  task automatic test_burst(input string name, input logic [4:0] base, input int len,
                            input int nwr, input int restart_cyc, input bit rnd_addr);
    int n;
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < nwr; i++) begin
      wq_a.push_back(rnd_addr ? 5'($urandom) : base + 5'd16 + 5'(i));
      wq_d.push_back(8'($urandom));
    end
    model_burst(base, len);
    burst_run(base, 6'(len), restart_cyc);
    checks++;
    if (obs_timeout) begin
      errors++; $display("FAIL %s timeout: burst did not finish in 300 cycles", name);
    end
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      errors++; $display("FAIL %s word_count: got %0d required %0d", name, obs_data.size(), exp_data.size());
    end
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_data[i] !== exp_data[i] || obs_vcyc[i] != exp_vcyc[i]) begin
        errors++;
        $display("FAIL %s word[%0d]: got %h@%0d required %h@%0d", name, i, obs_data[i], obs_vcyc[i], exp_data[i], exp_vcyc[i]);
      end
    end
    checks++;
    if (len > 0) begin
      if (obs_lcyc.size() != 1 || obs_lcyc[0] != exp_vcyc[exp_vcyc.size()-1]) begin
        errors++;
        $display("FAIL %s last: got %0d pulses first@%0d required 1@%0d", name, obs_lcyc.size(),
                 (obs_lcyc.size() > 0) ? obs_lcyc[0] : -1, exp_vcyc[exp_vcyc.size()-1]);
      end
    end else if (obs_lcyc.size() != 0) begin
      errors++; $display("FAIL %s last: got %0d pulses required 0", name, obs_lcyc.size());
    end
    checks++;
    if (obs_done_n != 1 || obs_done != exp_done) begin
      errors++; $display("FAIL %s done: got %0d pulses @%0d required 1 @%0d", name, obs_done_n, obs_done, exp_done);
    end
    checks++;
    if (obs_busy_n != exp_busy_n || (exp_busy_n > 0 && (obs_busy_first != 1 || obs_busy_last != exp_busy_n))) begin
      errors++;
      $display("FAIL %s busy: got %0d cycles %0d..%0d required %0d cycles 1..%0d",
               name, obs_busy_n, obs_busy_first, obs_busy_last, exp_busy_n, exp_busy_n);
    end
    checks++;
    if (obs_gcyc.size() != exp_gcyc.size()) begin
      errors++; $display("FAIL %s grant_count: got %0d required %0d", name, obs_gcyc.size(), exp_gcyc.size());
    end else begin
      for (int i = 0; i < obs_gcyc.size(); i++) begin
        checks++;
        if (obs_gcyc[i] != exp_gcyc[i]) begin
          errors++; $display("FAIL %s grant[%0d]: got cycle %0d required %0d", name, i, obs_gcyc[i], exp_gcyc[i]);
        end
      end
    end
    checks++;
    if (obs_bad != 0) begin
      errors++; $display("FAIL %s port_protocol: got %0d bad cycles required 0", name, obs_bad);
    end
`ifdef HIDDEN_RAM_CTRL_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL %s stall_cnt: got %0d required %0d", name, stall_cnt, exp_stall);
    end
`endif
  endtask

  task automatic test_full_burst;
    test_burst("full", 5'd0, 32, 0, 0, 1'b0);
    for (int i = 0; i < 32 && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL full_const[%0d]: got %h required %h", i, obs_data[i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] want [4];
    want[0] = 8'hBE; want[1] = 8'hBF; want[2] = 8'hA0; want[3] = 8'hA1;
    test_burst("wrap", 5'd30, 4, 0, 0, 1'b0);
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[i] !== want[i]) begin
        errors++; $display("FAIL wrap_const[%0d]: got %h required %h", i, obs_data[i], want[i]);
      end
    end
  endtask

  task automatic test_contention;
    int want_g [4];
    want_g[0] = 1; want_g[1] = 3; want_g[2] = 5; want_g[3] = 7;
    test_burst("contend", 5'd0, 8, 4, 0, 1'b0);
    for (int i = 0; i < 4 && i < obs_gcyc.size(); i++) begin
      checks++;
      if (obs_gcyc[i] != want_g[i]) begin
        errors++; $display("FAIL contend_alt[%0d]: got cycle %0d required %0d", i, obs_gcyc[i], want_g[i]);
      end
    end
    checks++;
    if (obs_done != 14) begin
      errors++; $display("FAIL contend_done: got cycle %0d required 14", obs_done);
    end
  endtask

  task automatic test_len_zero;
    test_burst("len0", 5'd9, 0, 0, 0, 1'b0);
    checks++;
    if (obs_done != 1 || obs_data.size() != 0 || obs_busy_n != 0) begin
      errors++; $display("FAIL len0_const: done@%0d words=%0d busy=%0d required 1 0 0", obs_done, obs_data.size(), obs_busy_n);
    end
  endtask

  task automatic test_start_ignored;
    test_burst("ignore", 5'd3, 6, 0, 2, 1'b0);
  endtask

  task automatic test_reset_mid_burst;
    int stray;
    seq_start = 1'b1; seq_base = 5'd0; seq_len = 6'd16;
    tick;
    seq_start = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ptr_m = 1'b0;
    #3;
    checks++;
    if ({seq_busy, seq_done, rd_valid, rd_last, hw_gnt, ram_if.ram_we} !== 6'b0 ||
        rd_data !== 8'h00 || ram_if.ram_addr !== 5'd0 || ram_if.ram_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b v=%b l=%b we=%b data=%h addr=%h required all 0",
               seq_busy, seq_done, rd_valid, rd_last, ram_if.ram_we, rd_data, ram_if.ram_addr);
    end
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      #3;
      if (seq_done !== 1'b0 || rd_valid !== 1'b0 || seq_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midrst_abandon: got %0d active cycles required 0", stray);
    end
    tick;
    test_burst("after_rst", 5'd5, 2, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      test_burst($sformatf("rand%0d", k), 5'($urandom), $urandom_range(1, 32),
                 $urandom_range(0, 5), 0, 1'b1);
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_host_fill;
    test_full_burst;
    test_wrap;
    test_contention;
    test_len_zero;
    test_start_ignored;
    test_reset_mid_burst;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
